pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Generic, parametrised inter-stage pipeline register: the successor to the fixed-field stage registers between decode/execute/memory/writeback.
- Carries one payload word (data plus control) per transfer under a valid/ready handshake.
- Supports synchronous flush that forces a bubble with all control zeroed.
- Optional 2-entry skid buffer so `in_ready` is registered (breaks the hazard-unit stall path).
- Saturating stall-cycle counter for debug-unit profiling.

Parameters:
- DATA_W, 32, width of datapath payload (register data, immediates, register indices packed by the instantiating stage).
- CTRL_W, 16, width of control payload (ALU op, mem op, reg write, halt, ...); forced to 0 on flush/reset.
- SKID, 1, 1 = two-entry skid buffer with registered `in_ready`; 0 = single register with combinational `in_ready`.
- CLEAR_DATA, 1, 1 = flush also zeroes data payload; 0 = flush clears only valid/ctrl (data holds stale value).
- CNT_W, 16, width of stall counter.

Ports:
- clk, input, 1, clock, all state on rising edge.
- reset, input, 1, asynchronous, active-low reset (0 = reset asserted); one clock; reset is asynchronous and active-low.
- flush, input, 1, synchronous clear (branch taken / exception), priority over every other input.
- in_valid, input, 1, upstream stage presents a word.
- in_ready, output, 1, this stage accepts a word this cycle.
- in_data, input, DATA_W, upstream data payload.
- in_ctrl, input, CTRL_W, upstream control payload.
- out_valid, output, 1, head word is valid.
- out_ready, input, 1, downstream consumes head word.
- out_data, output, DATA_W, head data payload.
- out_ctrl, output, CTRL_W, head control; 0 whenever `out_valid` = 0.
- occupancy, output, 2, number of held words (0..2; max 1 when SKID=0).
- stall_cnt, output, CNT_W, cycles with `out_valid` && !`out_ready`; saturating.
- stall_clr, input, 1, synchronous zeroing of `stall_cnt`.

Behaviour:
- Transfer rules: accept when `in_valid` && `in_ready`; pop when `out_valid` && `out_ready`. Latency is 1 cycle from accept to `out_valid` when empty. Order is strictly FIFO.
- Reset (`reset` = 0, asynchronous): `out_valid` = 0, `out_data` = 0, `out_ctrl` = 0, `occupancy` = 0, `stall_cnt` = 0, skid entry cleared. `in_ready` is 1 during and after reset.
- Flush (sync, highest priority):
  - Next state is EMPTY and `occupancy` = 0.
  - `out_ctrl` = 0; `out_data` = 0 if CLEAR_DATA, else unchanged.
  - A same-cycle accept is discarded and a same-cycle pop is ignored.
  - `stall_cnt` is unaffected.
- SKID=1, states EMPTY / ONE (main valid) / TWO (main + skid valid):
  - `in_ready` = !skid_valid, registered.
  - EMPTY: accept -> ONE.
  - ONE: accept & pop -> ONE (main <= input). Accept only -> TWO (skid <= input). Pop only -> EMPTY.
  - TWO: accepts are impossible. Pop -> ONE (main <= skid).
  - `out_*` always drive the main register.
- SKID=0:
  - `in_ready` = !out_valid || out_ready, combinational.
  - Single register. Accept & pop in the same cycle replaces the word.
  - `occupancy` ∈ {0, 1}.
- Valid gating: `out_ctrl` must read 0 whenever `out_valid` = 0, including after a pop to EMPTY. The main ctrl register is cleared on every transition to EMPTY.
- `stall_cnt`:
  - +1 each cycle `out_valid` && !`out_ready`.
  - Holds at 2^CNT_W − 1.
  - `stall_clr` zeroes it and has priority over increment.
- Unknowns: X on payload with `in_valid` = 0 never propagates to `out_ctrl`.

Test Plan:
- Reset mid-stream: SKID=1, two words 0xA1/0xB2 held, assert `reset` low asynchronously between clock edges -> all outputs 0 immediately, `occupancy` = 0, `in_ready` = 1.
- Backpressure fill: SKID=1, `out_ready` = 0, push 0x11, 0x22, 0x33 -> 0x11 and 0x22 accepted, `in_ready` = 0 on the cycle after 0x22, 0x33 held upstream. Release `out_ready` -> out sequence 0x11, 0x22, 0x33, `stall_cnt` = cycles stalled.
- Streaming: SKID=0 and SKID=1, `in_valid` = `out_ready` = 1, data 0..15 -> one word per cycle, latency 1, no drops/dups, `occupancy` ≤ 1.
- Flush collision: `occupancy` = 2, flush with `in_valid` = 1 and `out_ready` = 1 same cycle -> next cycle `out_valid` = 0, `out_ctrl` = 0, `out_data` = 0 (CLEAR_DATA=1) or stale (CLEAR_DATA=0), incoming word lost.
- Counter saturation: CNT_W=4, hold `out_valid` with `out_ready` = 0 for 20 cycles -> `stall_cnt` = 15. `stall_clr` with stall still active -> 0 that cycle, then increments to 1.
- Bubble control: pop to EMPTY after ctrl = 0xFFFF -> `out_ctrl` = 0x0000 while `out_valid` = 0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, optional 2-entry skid
// buffer, synchronous flush and a saturating stall counter for profiling.
module pipe_stage_reg #(
    parameter int DATA_W     = 32,
    parameter int CTRL_W     = 16,
    parameter int SKID       = 1,
    parameter int CLEAR_DATA = 1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stall_clr
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              mainValid;
    logic [DATA_W-1:0] mainData;
    logic [CTRL_W-1:0] mainCtrl;
    logic              skidValid;
    logic [DATA_W-1:0] skidData;
    logic [CTRL_W-1:0] skidCtrl;
    logic              accept;
    logic              pop;

    // With the skid buffer, in_ready is a pure flop output so the upstream stall
    // path never sees the downstream ready combinationally.
    assign in_ready  = (SKID != 0) ? !skidValid : (!mainValid || out_ready);
    assign accept    = in_valid && in_ready;
    assign pop       = mainValid && out_ready;

    assign out_valid = mainValid;
    assign out_data  = mainData;
    assign out_ctrl  = mainValid ? mainCtrl : '0;
    assign occupancy = {skidValid, mainValid & ~skidValid};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mainValid <= 1'b0;
            mainData  <= '0;
            mainCtrl  <= '0;
            skidValid <= 1'b0;
            skidData  <= '0;
            skidCtrl  <= '0;
        end else if (flush) begin
            mainValid <= 1'b0;
            mainCtrl  <= '0;
            skidValid <= 1'b0;
            skidCtrl  <= '0;
            if (CLEAR_DATA != 0) begin
                mainData <= '0;
                skidData <= '0;
            end
        end else if (SKID != 0) begin
            if (!mainValid) begin
                if (accept) begin
                    mainValid <= 1'b1;
                    mainData  <= in_data;
                    mainCtrl  <= in_ctrl;
                end
            end else if (!skidValid) begin
                if (accept && pop) begin
                    mainData <= in_data;
                    mainCtrl <= in_ctrl;
                end else if (accept) begin
                    skidValid <= 1'b1;
                    skidData  <= in_data;
                    skidCtrl  <= in_ctrl;
                end else if (pop) begin
                    mainValid <= 1'b0;
                    mainCtrl  <= '0;
                end
            end else if (pop) begin
                mainData  <= skidData;
                mainCtrl  <= skidCtrl;
                skidValid <= 1'b0;
                skidCtrl  <= '0;
            end
        end else begin
            if (accept) begin
                mainValid <= 1'b1;
                mainData  <= in_data;
                mainCtrl  <= in_ctrl;
            end else if (pop) begin
                mainValid <= 1'b0;
                mainCtrl  <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_cnt <= '0;
        else if (stall_clr)
            stall_cnt <= '0;
        else if (mainValid && !out_ready && stall_cnt != CNT_MAX)
            stall_cnt <= stall_cnt + 1'b1;
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: dutA = skid buffer, flush clears data, 4-bit counter;
// dutB = single register, flush keeps stale data, 16-bit counter.
module tb_pipe_stage_reg;

    typedef struct packed {
        logic        fl;
        logic        iv;
        logic [31:0] id;
        logic [15:0] ic;
        logic        ordy;
        logic        sclr;
    } in_t;

    typedef struct packed {
        logic        ov;
        logic [31:0] od;
        logic [15:0] oc;
        logic        ir;
        logic [1:0]  occ;
        logic [15:0] sc;
    } out_t;

    typedef struct {
        bit   b;
        in_t  i;
        out_t e;
    } vec_t;

    logic clk = 1'b0;
    logic rstA, rstB;
    in_t  inA, inB;
    out_t oA, oB;
    int   checks = 0;
    int   failures = 0;

    logic        ovA, irA, ovB, irB;
    logic [31:0] odA, odB;
    logic [15:0] ocA, ocB, scB;
    logic [1:0]  occA, occB;
    logic [3:0]  scA;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .SKID(1), .CLEAR_DATA(1), .CNT_W(4)) dutA (
        .clk(clk), .reset(rstA), .flush(inA.fl), .in_valid(inA.iv), .in_ready(irA),
        .in_data(inA.id), .in_ctrl(inA.ic), .out_valid(ovA), .out_ready(inA.ordy),
        .out_data(odA), .out_ctrl(ocA), .occupancy(occA), .stall_cnt(scA),
        .stall_clr(inA.sclr));

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .SKID(0), .CLEAR_DATA(0), .CNT_W(16)) dutB (
        .clk(clk), .reset(rstB), .flush(inB.fl), .in_valid(inB.iv), .in_ready(irB),
        .in_data(inB.id), .in_ctrl(inB.ic), .out_valid(ovB), .out_ready(inB.ordy),
        .out_data(odB), .out_ctrl(ocB), .occupancy(occB), .stall_cnt(scB),
        .stall_clr(inB.sclr));

    assign oA = {ovA, odA, ocA, irA, occA, {12'b0, scA}};
    assign oB = {ovB, odB, ocB, irB, occB, scB};

    function automatic in_t mkIn(logic fl, logic iv, logic [31:0] id, logic [15:0] ic,
                                 logic ordy, logic sclr);
        in_t v;
        v = '{fl: fl, iv: iv, id: id, ic: ic, ordy: ordy, sclr: sclr};
        return v;
    endfunction

    function automatic out_t mkOut(logic ov, logic [31:0] od, logic [15:0] oc, logic ir,
                                   logic [1:0] occ, logic [15:0] sc);
        out_t v;
        v = '{ov: ov, od: od, oc: oc, ir: ir, occ: occ, sc: sc};
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic chkOut(input string nm, input out_t a, input out_t e);
        chk({nm, ".out_valid"}, 64'(a.ov), 64'(e.ov));
        chk({nm, ".out_data"}, 64'(a.od), 64'(e.od));
        chk({nm, ".out_ctrl"}, 64'(a.oc), 64'(e.oc));
        chk({nm, ".in_ready"}, 64'(a.ir), 64'(e.ir));
        chk({nm, ".occupancy"}, 64'(a.occ), 64'(e.occ));
        chk({nm, ".stall_cnt"}, 64'(a.sc), 64'(e.sc));
    endtask

    // Inputs change on the falling edge and outputs are sampled 1 time unit after
    // the rising edge that consumed them, with the inputs still applied.
    task automatic drive(input bit b, input in_t v);
        @(negedge clk);
        if (b) inB = v;
        else   inA = v;
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[18];

    initial begin
        // dutA: backpressure fill, bubble gating, flush collision, start of a stall
        tbl[0]  = '{0, mkIn(0,1,32'h11,16'h0011,0,0), mkOut(1,32'h11,16'h0011,1,1,0)};
        tbl[1]  = '{0, mkIn(0,1,32'h22,16'h0022,0,0), mkOut(1,32'h11,16'h0011,0,2,1)};
        tbl[2]  = '{0, mkIn(0,1,32'h33,16'h0033,0,0), mkOut(1,32'h11,16'h0011,0,2,2)};
        tbl[3]  = '{0, mkIn(0,1,32'h33,16'h0033,0,0), mkOut(1,32'h11,16'h0011,0,2,3)};
        tbl[4]  = '{0, mkIn(0,1,32'h33,16'h0033,1,0), mkOut(1,32'h22,16'h0022,1,1,3)};
        tbl[5]  = '{0, mkIn(0,1,32'h33,16'h0033,1,0), mkOut(1,32'h33,16'h0033,1,1,3)};
        tbl[6]  = '{0, mkIn(0,0,32'h0,16'h0,1,0),     mkOut(0,32'h33,16'h0,1,0,3)};
        tbl[7]  = '{0, mkIn(0,1,32'h44,16'hFFFF,0,0), mkOut(1,32'h44,16'hFFFF,1,1,3)};
        tbl[8]  = '{0, mkIn(0,0,32'h0,16'hFFFF,1,0),  mkOut(0,32'h44,16'h0,1,0,3)};
        tbl[9]  = '{0, mkIn(0,1,32'hA1,16'h00A1,0,0), mkOut(1,32'hA1,16'h00A1,1,1,3)};
        tbl[10] = '{0, mkIn(0,1,32'hB2,16'h00B2,0,0), mkOut(1,32'hA1,16'h00A1,0,2,4)};
        tbl[11] = '{0, mkIn(1,1,32'hC3,16'h00C3,1,0), mkOut(0,32'h0,16'h0,1,0,4)};
        tbl[12] = '{0, mkIn(0,0,32'h0,16'h0,1,0),     mkOut(0,32'h0,16'h0,1,0,4)};
        tbl[13] = '{0, mkIn(0,1,32'h55,16'h0055,0,0), mkOut(1,32'h55,16'h0055,1,1,4)};
        // dutB after streaming: replace, combinational stall, flush keeps stale data
        tbl[14] = '{1, mkIn(0,1,32'h77,16'h0077,1,0), mkOut(1,32'h77,16'h0077,1,1,0)};
        tbl[15] = '{1, mkIn(0,1,32'h88,16'h0088,0,0), mkOut(1,32'h77,16'h0077,0,1,1)};
        tbl[16] = '{1, mkIn(1,1,32'h99,16'h0099,1,0), mkOut(0,32'h77,16'h0,1,0,1)};
        tbl[17] = '{1, mkIn(0,0,32'h0,16'h0,1,0),     mkOut(0,32'h77,16'h0,1,0,1)};

        rstA = 1'b0;
        rstB = 1'b0;
        inA  = '0;
        inB  = '0;
        #12;
        chkOut("resetA", oA, mkOut(0,0,0,1,0,0));
        chkOut("resetB", oB, mkOut(0,0,0,1,0,0));
        @(negedge clk);
        rstA = 1'b1;
        rstB = 1'b1;

        for (int r = 0; r < 14; r++) begin
            drive(tbl[r].b, tbl[r].i);
            chkOut($sformatf("rowA%0d", r), oA, tbl[r].e);
        end

        // Counter saturation: dutA holds 0x55 with no consumer
        for (int k = 0; k < 20; k++) drive(0, mkIn(0,0,0,0,0,0));
        chk("sat.stall_cnt", 64'(oA.sc), 64'd15);
        chk("sat.out_valid", 64'(oA.ov), 64'd1);
        drive(0, mkIn(0,0,0,0,0,1));
        chk("clr.stall_cnt", 64'(oA.sc), 64'd0);
        drive(0, mkIn(0,0,0,0,0,0));
        chk("clr_next.stall_cnt", 64'(oA.sc), 64'd1);
        drive(0, mkIn(1,0,0,0,0,0));
        chk("flushA.out_valid", 64'(oA.ov), 64'd0);

        // Streaming, one word per cycle with latency 1
        for (int k = 0; k < 16; k++) begin
            drive(0, mkIn(0,1,32'(k),16'(k) | 16'h0100,1,0));
            chkOut($sformatf("streamA%0d", k), oA, mkOut(1,32'(k),16'(k) | 16'h0100,1,1,2));
        end
        drive(0, mkIn(0,0,0,0,1,0));
        chkOut("streamA_end", oA, mkOut(0,32'd15,16'h0,1,0,2));

        // Reset mid-stream with two words held, asserted between edges
        drive(0, mkIn(0,1,32'hA1,16'h00A1,0,0));
        drive(0, mkIn(0,1,32'hB2,16'h00B2,0,0));
        chk("midA.occupancy", 64'(oA.occ), 64'd2);
        @(negedge clk);
        inA = '0;
        #2 rstA = 1'b0;
        #1 chkOut("async_reset", oA, mkOut(0,0,0,1,0,0));
        @(negedge clk);
        rstA = 1'b1;

        for (int k = 0; k < 16; k++) begin
            drive(1, mkIn(0,1,32'(k),16'(k) | 16'h0200,1,0));
            chkOut($sformatf("streamB%0d", k), oB, mkOut(1,32'(k),16'(k) | 16'h0200,1,1,0));
        end
        for (int r = 14; r < 18; r++) begin
            drive(tbl[r].b, tbl[r].i);
            chkOut($sformatf("rowB%0d", r), oB, tbl[r].e);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
